// File: rtl/mb_transform_scheduler.sv
// Ping-pong macroblock scheduler between sampler, six block transforms and block_vlc.
// Optional transform watchdog is enabled by defining XFORM_WATCHDOG_EN.
module mb_transform_scheduler #(
  parameter int NUM_BLOCKS    = 6,
  parameter int MB_PER_FRAME  = 99,
  parameter int XFORM_TIMEOUT = 2048
) (
  input  logic       clk_100mhz,
  input  logic       rst,
  input  logic       i_src_valid,
  output logic       o_src_ready,
  output logic       o_xform_start,
  output logic       o_xform_slot,
  input  logic       i_xform_done,
  input  logic       i_vlc_req,
  output logic       o_vlc_start,
  output logic       o_vlc_slot,
  output logic [2:0] o_vlc_block_idx,
  input  logic       i_vlc_done,
  output logic       o_pause,
  output logic       o_mb_last,
  output logic [6:0] o_mb_count,
  output logic       o_xform_err,
  output logic       o_dbg_fill_state,
  output logic [1:0] o_dbg_drain_state
);

  // Handshakes: src_valid is a level held by the sampler; src_ready pulses once when the
  // macroblock is taken. vlc_req/xform_done/vlc_done are single-cycle event pulses.
  typedef enum logic       {F_IDLE, F_BUSY}           fill_state_t;
  typedef enum logic [1:0] {D_IDLE, D_WAIT, D_STREAM} drain_state_t;

  localparam logic [2:0] IDX_LAST = 3'(NUM_BLOCKS - 1);
  localparam logic [6:0] MB_LAST  = 7'(MB_PER_FRAME - 1);

  fill_state_t  r_fill_state,  w_fill_next;
  drain_state_t r_drain_state, w_drain_next;

  logic [1:0] r_slot_full;
  logic       r_wr_slot;
  logic       r_rd_slot;
  logic       r_req_pending;
  logic [2:0] r_vlc_block_idx;
  logic [6:0] r_mb_count;
  logic       r_src_ready;
  logic       r_xform_start;
  logic       r_vlc_start;
  logic       r_pause;
  logic       r_mb_last;

  logic       w_wd_expire;
  logic       w_fill_accept;
  logic       w_xform_finish;
  logic       w_req;
  logic       w_rd_full;
  logic       w_last_blk;
  logic       w_blk_done;
  logic       w_mb_done;
  logic       w_vlc_start_nxt;
  logic       w_pause_nxt;
  logic       w_mb_last_nxt;
  logic [1:0] w_set_mask;
  logic [1:0] w_clr_mask;

  assign w_req      = i_vlc_req || r_req_pending;
  assign w_rd_full  = r_slot_full[r_rd_slot];
  assign w_last_blk = (r_vlc_block_idx == IDX_LAST);

  // Fill FSM
  always_ff @(posedge clk_100mhz) begin
    if (rst) r_fill_state <= F_IDLE;
    else     r_fill_state <= w_fill_next;
  end

  always_comb begin
    w_fill_next = r_fill_state;
    case (r_fill_state)
      F_IDLE:  if (i_src_valid && !r_slot_full[r_wr_slot]) w_fill_next = F_BUSY;
      F_BUSY:  if (i_xform_done || w_wd_expire) w_fill_next = F_IDLE;
      default: w_fill_next = F_IDLE;
    endcase
  end

  always_comb begin
    w_fill_accept  = 1'b0;
    w_xform_finish = 1'b0;
    case (r_fill_state)
      F_IDLE:  w_fill_accept  = i_src_valid && !r_slot_full[r_wr_slot];
      F_BUSY:  w_xform_finish = i_xform_done || w_wd_expire;
      default: ;
    endcase
    w_set_mask = w_xform_finish ? (2'b01 << r_wr_slot) : 2'b00;
  end

  // Drain FSM
  always_ff @(posedge clk_100mhz) begin
    if (rst) r_drain_state <= D_IDLE;
    else     r_drain_state <= w_drain_next;
  end

  always_comb begin
    w_drain_next = r_drain_state;
    case (r_drain_state)
      D_IDLE:   if (w_req) w_drain_next = w_rd_full ? D_STREAM : D_WAIT;
      D_WAIT:   if (w_rd_full) w_drain_next = D_STREAM;
      D_STREAM: if (i_vlc_done) w_drain_next = D_IDLE;
      default:  w_drain_next = D_IDLE;
    endcase
  end

  always_comb begin
    w_blk_done      = (r_drain_state == D_STREAM) && i_vlc_done;
    w_mb_done       = w_blk_done && w_last_blk;
    w_vlc_start_nxt = (r_drain_state != D_STREAM) && (w_drain_next == D_STREAM);
    w_pause_nxt     = (w_drain_next == D_WAIT);
    w_mb_last_nxt   = w_vlc_start_nxt && w_last_blk && (r_mb_count == MB_LAST);
    w_clr_mask      = w_mb_done ? (2'b01 << r_rd_slot) : 2'b00;
  end

  // Slot bookkeeping; fill only ever sets an empty slot, so set and clear never collide.
  always_ff @(posedge clk_100mhz) begin
    if (rst) begin
      r_slot_full     <= 2'b00;
      r_wr_slot       <= 1'b0;
      r_rd_slot       <= 1'b0;
      r_req_pending   <= 1'b0;
      r_vlc_block_idx <= 3'd0;
      r_mb_count      <= 7'd0;
      r_src_ready     <= 1'b0;
      r_xform_start   <= 1'b0;
      r_vlc_start     <= 1'b0;
      r_pause         <= 1'b0;
      r_mb_last       <= 1'b0;
    end else begin
      r_src_ready   <= w_fill_accept;
      r_xform_start <= w_fill_accept;
      r_vlc_start   <= w_vlc_start_nxt;
      r_pause       <= w_pause_nxt;
      r_mb_last     <= w_mb_last_nxt;
      r_slot_full   <= (r_slot_full | w_set_mask) & ~w_clr_mask;
      if (w_xform_finish) r_wr_slot <= ~r_wr_slot;
      if (w_blk_done) begin
        if (w_last_blk) begin
          r_vlc_block_idx <= 3'd0;
          r_rd_slot       <= ~r_rd_slot;
          r_mb_count      <= (r_mb_count == MB_LAST) ? 7'd0 : r_mb_count + 7'd1;
        end else begin
          r_vlc_block_idx <= r_vlc_block_idx + 3'd1;
        end
      end
      // A request is consumed when D_IDLE acts on it; only D_STREAM needs to remember one.
      if (r_drain_state == D_IDLE && w_req)
        r_req_pending <= 1'b0;
      else if (r_drain_state == D_STREAM && i_vlc_req)
        r_req_pending <= 1'b1;
    end
  end

`ifdef XFORM_WATCHDOG_EN
  localparam int WD_W = $clog2(XFORM_TIMEOUT);
  logic [WD_W-1:0] r_wd_cnt;
  logic            r_xform_err;

  assign w_wd_expire = (r_fill_state == F_BUSY) && (r_wd_cnt == WD_W'(XFORM_TIMEOUT - 1));

  always_ff @(posedge clk_100mhz) begin
    if (rst || r_fill_state != F_BUSY) r_wd_cnt <= '0;
    else                               r_wd_cnt <= r_wd_cnt + WD_W'(1);
    if (rst)                                r_xform_err <= 1'b0;
    else if (w_wd_expire && !i_xform_done) r_xform_err <= 1'b1;
  end

  assign o_xform_err = r_xform_err;
`else
  assign w_wd_expire = 1'b0;
  assign o_xform_err = 1'b0;
`endif

  assign o_src_ready       = r_src_ready;
  assign o_xform_start     = r_xform_start;
  assign o_xform_slot      = r_wr_slot;
  assign o_vlc_start       = r_vlc_start;
  assign o_vlc_slot        = r_rd_slot;
  assign o_vlc_block_idx   = r_vlc_block_idx;
  assign o_pause           = r_pause;
  assign o_mb_last         = r_mb_last;
  assign o_mb_count        = r_mb_count;
  assign o_dbg_fill_state  = r_fill_state;
  assign o_dbg_drain_state = r_drain_state;

endmodule
